// File: rtl/branch_predictor_pkg.sv
// Shared constants for the branch predictor: counter encodings, PC field
// positions and the logical entry layout.
package branch_predictor_pkg;

  // 2-bit counter encodings; wider counters keep the MSB as the taken bit.
  localparam logic [1:0] CTR2_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR2_WEAK_NT   = 2'b01;
  localparam logic [1:0] CTR2_WEAK_T    = 2'b10;
  localparam logic [1:0] CTR2_STRONG_T  = 2'b11;

  // Instructions are word aligned, so the index starts at PC bit 2.
  localparam int IDX_LSB = 2;

  function automatic int tag_lsb(input int index_w);
    return index_w + IDX_LSB;
  endfunction

  function automatic int unsigned ctr_weak_nt(input int ctr_w);
    return (32'd1 << (ctr_w - 1)) - 32'd1;
  endfunction

  function automatic int unsigned ctr_weak_t(input int ctr_w);
    return 32'd1 << (ctr_w - 1);
  endfunction

  // Entry field order {valid, tag, target, ctr} for the default geometry.
  typedef struct packed {
    logic        valid;
    logic [7:0]  tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } entry_default_t;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, MEM-stage update and performance counter signals.
interface branch_predictor_if #(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 8,
  parameter int CNT_W   = 32
);
  // lookup_en qualifies LOOKUP_PC for a same-cycle prediction and upd_en is a
  // one-cycle pulse per resolved branch; there is no ready/backpressure.
  logic               lookup_en;
  logic [ADDR_W-1:0]  LOOKUP_PC;
  logic               pred_taken;
  logic               pred_hit;
  logic [ADDR_W-1:0]  PRED_TARGET;
  logic [INDEX_W-1:0] PRED_INDEX;
  logic               upd_en;
  logic [ADDR_W-1:0]  UPD_PC;
  logic [INDEX_W-1:0] UPD_INDEX;
  logic               upd_taken;
  logic [ADDR_W-1:0]  UPD_TARGET;
  logic               upd_mispredict;
  logic [CNT_W-1:0]   BRANCH_COUNT;
  logic [CNT_W-1:0]   MISPREDICT_COUNT;

  modport master (
    output lookup_en, LOOKUP_PC, upd_en, UPD_PC, UPD_INDEX, upd_taken,
           UPD_TARGET, upd_mispredict,
    input  pred_taken, pred_hit, PRED_TARGET, PRED_INDEX, BRANCH_COUNT,
           MISPREDICT_COUNT
  );

  modport slave (
    input  lookup_en, LOOKUP_PC, upd_en, UPD_PC, UPD_INDEX, upd_taken,
           UPD_TARGET, upd_mispredict,
    output pred_taken, pred_hit, PRED_TARGET, PRED_INDEX, BRANCH_COUNT,
           MISPREDICT_COUNT
  );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down counter next-value logic; holds when both or neither
// of inc/dec are set.
module sat_counter #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] value,
  input  logic             inc,
  input  logic             dec,
  output logic [CTR_W-1:0] result
);
  always_comb begin
    result = value;
    if (inc && !dec && (value != '1)) begin
      result = value + 1'b1;
    end else if (dec && !inc && (value != '0)) begin
      result = value - 1'b1;
    end
  end
endmodule

// File: rtl/branch_predictor.sv
// Tagged branch prediction table with saturating counters, optional gshare
// indexing and saturating branch/mispredict counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INDEX_W = 8,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2,
  parameter int GSHARE  = 0,
  parameter int CNT_W   = 32
) (
  input logic               clk,
  input logic               reset,
  branch_predictor_if.slave bus
);
  localparam int ENTRIES = 1 << INDEX_W;
  localparam int T_LSB   = tag_lsb(INDEX_W);
  localparam logic [CTR_W-1:0] CTR_INIT  = CTR_W'(ctr_weak_nt(CTR_W));
  localparam logic [CTR_W-1:0] CTR_ALLOC = CTR_W'(ctr_weak_t(CTR_W));

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [CTR_W-1:0]  ctr_q    [ENTRIES];
  logic [INDEX_W-1:0] ghr_q;
  logic [CNT_W-1:0]   branch_cnt_q;
  logic [CNT_W-1:0]   mispredict_cnt_q;

  logic [INDEX_W-1:0] lk_index;
  logic [TAG_W-1:0]   lk_tag;
  logic               lk_hit;
  logic [TAG_W-1:0]   upd_tag;
  logic               upd_hit;
  logic [CTR_W-1:0]   ctr_next;
  logic               unused_pc_bits;

  // Lookup reads the flop array directly, so a same-cycle update is not seen.
  always_comb begin
    lk_index = bus.LOOKUP_PC[INDEX_W+1:IDX_LSB];
    if (GSHARE != 0) lk_index = lk_index ^ ghr_q;
    lk_tag = bus.LOOKUP_PC[T_LSB+TAG_W-1:T_LSB];
    lk_hit = bus.lookup_en && valid_q[lk_index] && (tag_q[lk_index] == lk_tag);
  end

  assign bus.PRED_INDEX       = lk_index;
  assign bus.pred_hit         = lk_hit;
  assign bus.pred_taken       = lk_hit && ctr_q[lk_index][CTR_W-1];
  assign bus.PRED_TARGET      = lk_hit ? target_q[lk_index] : '0;
  assign bus.BRANCH_COUNT     = branch_cnt_q;
  assign bus.MISPREDICT_COUNT = mispredict_cnt_q;

  // The update entry comes from the index captured at fetch, not from UPD_PC,
  // because the history may have moved since the prediction was made.
  assign upd_tag = bus.UPD_PC[T_LSB+TAG_W-1:T_LSB];
  assign upd_hit = valid_q[bus.UPD_INDEX] && (tag_q[bus.UPD_INDEX] == upd_tag);

  assign unused_pc_bits = ^{bus.LOOKUP_PC[ADDR_W-1:T_LSB+TAG_W], bus.LOOKUP_PC[1:0],
                            bus.UPD_PC[ADDR_W-1:T_LSB+TAG_W], bus.UPD_PC[T_LSB-1:0]};

  sat_counter #(.CTR_W(CTR_W)) u_ctr (
    .value  (ctr_q[bus.UPD_INDEX]),
    .inc    (bus.upd_taken),
    .dec    (!bus.upd_taken),
    .result (ctr_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_INIT;
      end
    end else if (bus.upd_en) begin
      if (upd_hit) begin
        ctr_q[bus.UPD_INDEX] <= ctr_next;
        if (bus.upd_taken) target_q[bus.UPD_INDEX] <= bus.UPD_TARGET;
      end else if (bus.upd_taken) begin
        valid_q[bus.UPD_INDEX]  <= 1'b1;
        tag_q[bus.UPD_INDEX]    <= upd_tag;
        target_q[bus.UPD_INDEX] <= bus.UPD_TARGET;
        ctr_q[bus.UPD_INDEX]    <= CTR_ALLOC;
      end
    end
  end

  // History is non-speculative: it only advances on resolved branches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ghr_q <= '0;
    end else if (bus.upd_en) begin
      ghr_q <= {ghr_q[INDEX_W-2:0], bus.upd_taken};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (bus.upd_en) begin
      if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 1'b1;
      if (bus.upd_mispredict && (mispredict_cnt_q != '1))
        mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: bimodal table vectors, alias/stall/reset
// sequences, and a gshare instance with narrow saturating counters.
module tb_branch_predictor;
  localparam int EW = 1 + 1 + 32 + 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   exp_bc = 0;
  int   exp_mc = 0;
  logic [EW-1:0] exp_q[$];

  branch_predictor_if #(.ADDR_W(32), .INDEX_W(8), .CNT_W(32)) bp_if ();
  branch_predictor_if #(.ADDR_W(32), .INDEX_W(8), .CNT_W(3))  gs_if ();

  branch_predictor #(.GSHARE(0), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bp_if)
  );
  branch_predictor #(.GSHARE(1), .CNT_W(3)) dut_gs (
    .clk(clk), .reset(reset), .bus(gs_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        lk_en;
    logic [31:0] lk_pc;
    logic        upd;
    logic [31:0] u_pc;
    logic [7:0]  u_idx;
    logic        u_tk;
    logic [31:0] u_tgt;
    logic        u_mp;
    logic        e_hit;
    logic        e_tk;
    logic [31:0] e_tgt;
    logic [7:0]  e_idx;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic lk_en, logic [31:0] lk_pc, logic upd, logic [31:0] u_pc,
                             logic [7:0] u_idx, logic u_tk, logic [31:0] u_tgt, logic u_mp,
                             logic e_hit, logic e_tk, logic [31:0] e_tgt, logic [7:0] e_idx);
    vec_t r;
    r.lk_en = lk_en; r.lk_pc = lk_pc; r.upd = upd; r.u_pc = u_pc; r.u_idx = u_idx;
    r.u_tk = u_tk; r.u_tgt = u_tgt; r.u_mp = u_mp;
    r.e_hit = e_hit; r.e_tk = e_tk; r.e_tgt = e_tgt; r.e_idx = e_idx;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic idle_bp();
    bp_if.lookup_en = 1'b0; bp_if.LOOKUP_PC = '0; bp_if.upd_en = 1'b0;
    bp_if.UPD_PC = '0; bp_if.UPD_INDEX = '0; bp_if.upd_taken = 1'b0;
    bp_if.UPD_TARGET = '0; bp_if.upd_mispredict = 1'b0;
  endtask

  task automatic gs_update(input logic tk, input logic mp);
    @(negedge clk);
    gs_if.upd_en = 1'b1; gs_if.upd_taken = tk; gs_if.upd_mispredict = mp;
    gs_if.UPD_PC = 32'h40; gs_if.UPD_INDEX = 8'h10; gs_if.UPD_TARGET = 32'h100;
  endtask

  task automatic bp_lookup_hit(input string name, input logic [31:0] pc, input logic exp_hit);
    bp_if.lookup_en = 1'b1; bp_if.LOOKUP_PC = pc;
    #1;
    check(name, 64'(bp_if.pred_hit), 64'(exp_hit));
  endtask

  initial begin
    logic [EW-1:0] got;
    logic [EW-1:0] exp;

    idle_bp();
    gs_if.lookup_en = 1'b0; gs_if.LOOKUP_PC = '0; gs_if.upd_en = 1'b0;
    gs_if.UPD_PC = '0; gs_if.UPD_INDEX = '0; gs_if.upd_taken = 1'b0;
    gs_if.UPD_TARGET = '0; gs_if.upd_mispredict = 1'b0;

    // Bimodal vectors: lookup outputs reflect table state before the row's update.
    vecs.push_back(v(1, 32'h40,  0, 32'h0,   8'h00, 0, 32'h0,   0, 0, 0, 32'h0,   8'h10));
    vecs.push_back(v(1, 32'h40,  1, 32'h40,  8'h10, 1, 32'h100, 1, 0, 0, 32'h0,   8'h10));
    vecs.push_back(v(1, 32'h40,  0, 32'h0,   8'h00, 0, 32'h0,   0, 1, 1, 32'h100, 8'h10));
    vecs.push_back(v(1, 32'h40,  1, 32'h40,  8'h10, 0, 32'h100, 1, 1, 1, 32'h100, 8'h10));
    vecs.push_back(v(1, 32'h40,  1, 32'h40,  8'h10, 0, 32'h100, 0, 1, 0, 32'h100, 8'h10));
    vecs.push_back(v(1, 32'h40,  1, 32'h40,  8'h10, 0, 32'h100, 0, 1, 0, 32'h100, 8'h10));
    vecs.push_back(v(1, 32'h40,  1, 32'h40,  8'h10, 1, 32'h100, 1, 1, 0, 32'h100, 8'h10));
    vecs.push_back(v(1, 32'h40,  1, 32'h40,  8'h10, 1, 32'h100, 0, 1, 0, 32'h100, 8'h10));
    vecs.push_back(v(1, 32'h40,  1, 32'h40,  8'h10, 1, 32'h200, 0, 1, 1, 32'h100, 8'h10));
    vecs.push_back(v(1, 32'h40,  1, 32'h40,  8'h10, 1, 32'h200, 0, 1, 1, 32'h200, 8'h10));
    vecs.push_back(v(1, 32'h40,  1, 32'h40,  8'h10, 0, 32'h300, 1, 1, 1, 32'h200, 8'h10));
    vecs.push_back(v(1, 32'h40,  0, 32'h0,   8'h00, 0, 32'h0,   0, 1, 1, 32'h200, 8'h10));
    vecs.push_back(v(1, 32'h440, 0, 32'h0,   8'h00, 0, 32'h0,   0, 0, 0, 32'h0,   8'h10));
    vecs.push_back(v(1, 32'h440, 1, 32'h440, 8'h10, 1, 32'h500, 0, 0, 0, 32'h0,   8'h10));
    vecs.push_back(v(1, 32'h440, 0, 32'h0,   8'h00, 0, 32'h0,   0, 1, 1, 32'h500, 8'h10));
    vecs.push_back(v(1, 32'h40,  0, 32'h0,   8'h00, 0, 32'h0,   0, 0, 0, 32'h0,   8'h10));
    vecs.push_back(v(1, 32'h80,  1, 32'h80,  8'h20, 0, 32'h600, 0, 0, 0, 32'h0,   8'h20));
    vecs.push_back(v(1, 32'h80,  0, 32'h0,   8'h00, 0, 32'h0,   0, 0, 0, 32'h0,   8'h20));
    vecs.push_back(v(0, 32'h440, 1, 32'h440, 8'h10, 1, 32'h500, 0, 0, 0, 32'h0,   8'h10));
    vecs.push_back(v(1, 32'hC0,  1, 32'hC0,  8'h10, 1, 32'h700, 1, 0, 0, 32'h0,   8'h30));
    vecs.push_back(v(1, 32'h40,  0, 32'h0,   8'h00, 0, 32'h0,   0, 1, 1, 32'h700, 8'h10));
    vecs.push_back(v(1, 32'hC0,  0, 32'h0,   8'h00, 0, 32'h0,   0, 0, 0, 32'h0,   8'h30));

    repeat (3) @(negedge clk);
    #1;
    check("reset branch_count", 64'(bp_if.BRANCH_COUNT), 64'd0);
    check("reset mispredict_count", 64'(bp_if.MISPREDICT_COUNT), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      bp_if.lookup_en = vecs[i].lk_en; bp_if.LOOKUP_PC = vecs[i].lk_pc;
      bp_if.upd_en = vecs[i].upd; bp_if.UPD_PC = vecs[i].u_pc;
      bp_if.UPD_INDEX = vecs[i].u_idx; bp_if.upd_taken = vecs[i].u_tk;
      bp_if.UPD_TARGET = vecs[i].u_tgt; bp_if.upd_mispredict = vecs[i].u_mp;
      exp_q.push_back({vecs[i].e_hit, vecs[i].e_tk, vecs[i].e_tgt, vecs[i].e_idx});
      if (vecs[i].upd) begin
        exp_bc++;
        if (vecs[i].u_mp) exp_mc++;
      end
      #1;
      got = {bp_if.pred_hit, bp_if.pred_taken, bp_if.PRED_TARGET, bp_if.PRED_INDEX};
      exp = exp_q.pop_front();
      check($sformatf("vec %0d {hit,taken,target,index}", i), 64'(got), 64'(exp));
    end
    @(negedge clk);
    idle_bp();
    #1;
    check("table branch_count", 64'(bp_if.BRANCH_COUNT), 64'(exp_bc));
    check("table mispredict_count", 64'(bp_if.MISPREDICT_COUNT), 64'(exp_mc));

    // Gshare history: T, T, NT gives GHR 0b110.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    gs_update(1'b1, 1'b0);
    gs_update(1'b1, 1'b0);
    gs_update(1'b0, 1'b0);
    @(negedge clk);
    gs_if.upd_en = 1'b0; gs_if.lookup_en = 1'b1; gs_if.LOOKUP_PC = 32'h40;
    #1;
    check("gshare pred_index", 64'(gs_if.PRED_INDEX), 64'h16);
    check("gshare branch_count", 64'(gs_if.BRANCH_COUNT), 64'd3);
    for (int k = 0; k < 6; k++) gs_update(1'b0, 1'b1);
    @(negedge clk);
    gs_if.upd_en = 1'b0;
    #1;
    check("gshare branch_count saturates", 64'(gs_if.BRANCH_COUNT), 64'd7);
    check("gshare mispredict_count", 64'(gs_if.MISPREDICT_COUNT), 64'd6);

    // Counters and table clear asynchronously mid-operation.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("async reset branch_count", 64'(bp_if.BRANCH_COUNT), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bp_if.upd_en = 1'b1; bp_if.UPD_PC = 32'h40; bp_if.UPD_INDEX = 8'h10;
      bp_if.upd_taken = 1'b1; bp_if.UPD_TARGET = 32'h100;
      bp_if.upd_mispredict = (k == 1 || k == 3);
    end
    @(negedge clk);
    idle_bp();
    #1;
    check("five updates branch_count", 64'(bp_if.BRANCH_COUNT), 64'd5);
    check("five updates mispredict_count", 64'(bp_if.MISPREDICT_COUNT), 64'd2);
    bp_lookup_hit("hit before reset", 32'h40, 1'b1);
    @(negedge clk);
    bp_if.upd_en = 1'b1; bp_if.UPD_PC = 32'h80; bp_if.UPD_INDEX = 8'h20;
    bp_if.upd_taken = 1'b1; bp_if.upd_mispredict = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    check("mid reset branch_count", 64'(bp_if.BRANCH_COUNT), 64'd0);
    check("mid reset mispredict_count", 64'(bp_if.MISPREDICT_COUNT), 64'd0);
    bp_lookup_hit("mid reset table invalid", 32'h40, 1'b0);
    @(negedge clk);
    bp_if.upd_en = 1'b0;
    reset = 1'b1;
    #1;
    check("update during reset discarded", 64'(bp_if.BRANCH_COUNT), 64'd0);
    bp_lookup_hit("update during reset no alloc", 32'h80, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
